// File: rtl/decode_stage.sv
// ID/EX decode stage for the 3-bit-opcode core.
// Decodes opcode and register fields into registered EX controls behind a
// valid/ready handshake on both sides. A load-use hazard inserts one bubble.
// The stage also supports flush, reports illegal opcodes, and keeps a
// saturating count of hazard-stall cycles.
module decode_stage #(
   parameter int REG_ADDR_W = 3,
   parameter int IMM_W      = 8,
   parameter int CNT_W      = 16,
   parameter bit REG0_ZERO  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            in_op,
   input  logic [REG_ADDR_W-1:0] in_rd,
   input  logic [REG_ADDR_W-1:0] in_rs1,
   input  logic [REG_ADDR_W-1:0] in_rs2,
   input  logic [IMM_W-1:0]      in_imm,
   input  logic                  flush,
   output logic                  ex_valid,
   input  logic                  ex_ready,
   output logic                  ex_regwrite,
   output logic                  ex_aluop,
   output logic                  ex_alusrc,
   output logic                  ex_memwrite,
   output logic                  ex_memtoreg,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic [REG_ADDR_W-1:0] ex_rs1,
   output logic [REG_ADDR_W-1:0] ex_rs2,
   output logic [IMM_W-1:0]      ex_imm,
   output logic                  illegal,
   output logic [CNT_W-1:0]      stall_count
);

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_ADDI = 3'd1;
   localparam logic [2:0] OP_SW   = 3'd2;
   localparam logic [2:0] OP_LW   = 3'd3;
   localparam logic [2:0] OP_SLL  = 3'd4;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};
   localparam logic [CNT_W-1:0]      CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1'b1);

   // Decoded view of one opcode: EX controls plus legality and source usage.
   typedef struct packed {
      logic regwrite;
      logic aluop;
      logic alusrc;
      logic memwrite;
      logic memtoreg;
      logic legal;
      logic use_rs1;
      logic use_rs2;
   } dec_t;

   localparam dec_t DEC_NONE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

   // Opcode table. Illegal opcodes read no sources, so they never cause a stall.
   function automatic dec_t decode_op(input logic [2:0] op);
      dec_t d;
      d = DEC_NONE;
      case (op)
         OP_ADD:  d = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
         OP_ADDI: d = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
         OP_SW:   d = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
         OP_LW:   d = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
         OP_SLL:  d = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
         default: d = DEC_NONE;
      endcase
      return d;
   endfunction

   dec_t dec_s;
   logic adv_s;
   logic rd_live_s;
   logic src_match_s;
   logic hazard_s;
   logic accept_s;
   logic stall_evt_s;

   // Decode the offered instruction. A write to the zero register is dropped.
   always_comb begin
      dec_s = decode_op(in_op);
      if (REG0_ZERO && (in_rd == REG_ZERO)) begin
         dec_s.regwrite = 1'b0;
      end else begin
         dec_s.regwrite = dec_s.regwrite;
      end
   end

   // Load-use hazard detection and handshake. A load to r0 never blocks a consumer.
   always_comb begin
      adv_s       = ~ex_valid | ex_ready;
      rd_live_s   = ~(REG0_ZERO && (ex_rd == REG_ZERO));
      src_match_s = (dec_s.use_rs1 && (in_rs1 == ex_rd)) ||
                    (dec_s.use_rs2 && (in_rs2 == ex_rd));
      hazard_s    = ex_valid & ex_memtoreg & rd_live_s & src_match_s;
      in_ready    = adv_s & ~hazard_s & ~flush;
      accept_s    = in_valid & in_ready;
      stall_evt_s = in_valid & hazard_s & adv_s & ~flush;
   end

   // EX pipeline register. Priority is reset, then flush, then advance; with adv=0 it holds.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid    <= 1'b0;
         ex_regwrite <= 1'b0;
         ex_aluop    <= 1'b0;
         ex_alusrc   <= 1'b0;
         ex_memwrite <= 1'b0;
         ex_memtoreg <= 1'b0;
         ex_rd       <= REG_ZERO;
         ex_rs1      <= REG_ZERO;
         ex_rs2      <= REG_ZERO;
         ex_imm      <= {IMM_W{1'b0}};
         illegal     <= 1'b0;
      end else if (flush) begin
         // Kill the EX slot. The offered instruction is not taken.
         ex_valid    <= 1'b0;
         ex_regwrite <= 1'b0;
         ex_aluop    <= 1'b0;
         ex_alusrc   <= 1'b0;
         ex_memwrite <= 1'b0;
         ex_memtoreg <= 1'b0;
         illegal     <= 1'b0;
      end else if (accept_s) begin
         // An illegal opcode is consumed, but it becomes a bubble with all controls low.
         ex_valid    <= dec_s.legal;
         ex_regwrite <= dec_s.legal & dec_s.regwrite;
         ex_aluop    <= dec_s.legal & dec_s.aluop;
         ex_alusrc   <= dec_s.legal & dec_s.alusrc;
         ex_memwrite <= dec_s.legal & dec_s.memwrite;
         ex_memtoreg <= dec_s.legal & dec_s.memtoreg;
         ex_rd       <= in_rd;
         ex_rs1      <= in_rs1;
         ex_rs2      <= in_rs2;
         ex_imm      <= in_imm;
         illegal     <= ~dec_s.legal;
      end else if (adv_s) begin
         // Nothing accepted: a hazard bubble, or no instruction was offered.
         ex_valid    <= 1'b0;
         ex_regwrite <= 1'b0;
         ex_aluop    <= 1'b0;
         ex_alusrc   <= 1'b0;
         ex_memwrite <= 1'b0;
         ex_memtoreg <= 1'b0;
         illegal     <= 1'b0;
      end else begin
         // EX is back-pressured: the EX contents hold.
         illegal     <= 1'b0;
      end
   end

   // Saturating count of cycles in which a load-use hazard stalled an offered instruction.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_count <= {CNT_W{1'b0}};
      end else if (stall_evt_s && (stall_count != CNT_MAX)) begin
         stall_count <= stall_count + CNT_ONE;
      end else begin
         stall_count <= stall_count;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Directed, table-driven bench for decode_stage. It uses a 3-bit stall counter
// so that saturation can be reached.
module tb_decode_stage;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [2:0] in_op = 3'd0;
   logic [2:0] in_rd = 3'd0;
   logic [2:0] in_rs1 = 3'd0;
   logic [2:0] in_rs2 = 3'd0;
   logic [7:0] in_imm = 8'd0;
   logic       flush = 1'b0;
   logic       ex_valid;
   logic       ex_ready = 1'b1;
   logic       ex_regwrite, ex_aluop, ex_alusrc, ex_memwrite, ex_memtoreg;
   logic [2:0] ex_rd, ex_rs1, ex_rs2;
   logic [7:0] ex_imm;
   logic       illegal;
   logic [2:0] stall_count;

   decode_stage #(.REG_ADDR_W(3), .IMM_W(8), .CNT_W(3), .REG0_ZERO(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_regwrite(ex_regwrite), .ex_aluop(ex_aluop), .ex_alusrc(ex_alusrc),
      .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
      .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm),
      .illegal(illegal), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   // Control vector order: {regwrite, aluop, alusrc, memwrite, memtoreg}.
   localparam logic [4:0] C_NONE = 5'b00000;
   localparam logic [4:0] C_ADD  = 5'b10000;
   localparam logic [4:0] C_ADDI = 5'b10100;
   localparam logic [4:0] C_SW   = 5'b00110;
   localparam logic [4:0] C_LW   = 5'b10101;
   localparam logic [4:0] C_LW0  = 5'b00101;
   localparam logic [4:0] C_SLL  = 5'b11000;

   typedef struct {
      logic       rst, flush, iv;
      logic [2:0] op, rd, rs1, rs2;
      logic [7:0] imm;
      logic       er;
      logic       x_rdy, x_valid;
      logic [4:0] x_ctl;
      logic       cc, cf;
      logic [2:0] x_rd, x_rs1, x_rs2;
      logic [7:0] x_imm;
      logic       x_ill;
      logic [2:0] x_cnt;
   } vec_t;

   vec_t tbl[$];
   int   total = 0;
   int   bad = 0;
   int   cur_row = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, cur_row, act, exp);
      end
   endtask

   task automatic add_vec(input logic r, fl, iv, input logic [2:0] op, rd, rs1, rs2,
                          input logic [7:0] imm, input logic er,
                          input logic x_rdy, x_valid, input logic [4:0] x_ctl,
                          input logic cc, cf, input logic [2:0] x_rd, x_rs1, x_rs2,
                          input logic [7:0] x_imm, input logic x_ill, input logic [2:0] x_cnt);
      vec_t v;
      v.rst = r; v.flush = fl; v.iv = iv; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
      v.imm = imm; v.er = er; v.x_rdy = x_rdy; v.x_valid = x_valid; v.x_ctl = x_ctl;
      v.cc = cc; v.cf = cf; v.x_rd = x_rd; v.x_rs1 = x_rs1; v.x_rs2 = x_rs2;
      v.x_imm = x_imm; v.x_ill = x_ill; v.x_cnt = x_cnt;
      tbl.push_back(v);
   endtask

   task automatic drive(input logic r, fl, iv, input logic [2:0] op, rd, rs1, rs2,
                        input logic [7:0] imm, input logic er);
      @(negedge clk);
      rst = r; flush = fl; in_valid = iv; in_op = op; in_rd = rd;
      in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; ex_ready = er;
      #1;
   endtask

   function automatic logic [4:0] ctl_now();
      return {ex_regwrite, ex_aluop, ex_alusrc, ex_memwrite, ex_memtoreg};
   endfunction

   initial begin
      // Stimulus and expected results, one row per clock.
      //      rst fl iv op    rd    rs1   rs2   imm     er  | rdy val ctl    cc cf rd    rs1   rs2   imm    ill cnt
      add_vec(0, 0, 1, 3'd0, 3'd1, 3'd2, 3'd3, 8'h11, 1,   1, 1, C_ADD,  1, 1, 3'd1, 3'd2, 3'd3, 8'h11, 0, 3'd0);
      add_vec(0, 0, 1, 3'd3, 3'd4, 3'd2, 3'd0, 8'h22, 1,   1, 1, C_LW,   1, 1, 3'd4, 3'd2, 3'd0, 8'h22, 0, 3'd0);
      add_vec(0, 0, 1, 3'd0, 3'd5, 3'd6, 3'd4, 8'h33, 1,   0, 0, C_NONE, 1, 0, 3'd0, 3'd0, 3'd0, 8'h00, 0, 3'd1);
      add_vec(0, 0, 1, 3'd0, 3'd5, 3'd6, 3'd4, 8'h33, 1,   1, 1, C_ADD,  1, 1, 3'd5, 3'd6, 3'd4, 8'h33, 0, 3'd1);
      add_vec(0, 0, 1, 3'd3, 3'd4, 3'd1, 3'd0, 8'h44, 1,   1, 1, C_LW,   1, 1, 3'd4, 3'd1, 3'd0, 8'h44, 0, 3'd1);
      add_vec(0, 0, 1, 3'd1, 3'd6, 3'd5, 3'd4, 8'h55, 1,   1, 1, C_ADDI, 1, 1, 3'd6, 3'd5, 3'd4, 8'h55, 0, 3'd1);
      add_vec(0, 0, 1, 3'd3, 3'd0, 3'd1, 3'd0, 8'h66, 1,   1, 1, C_LW0,  1, 1, 3'd0, 3'd1, 3'd0, 8'h66, 0, 3'd1);
      add_vec(0, 0, 1, 3'd0, 3'd7, 3'd0, 3'd0, 8'h77, 1,   1, 1, C_ADD,  1, 1, 3'd7, 3'd0, 3'd0, 8'h77, 0, 3'd1);
      add_vec(0, 0, 1, 3'd2, 3'd0, 3'd1, 3'd2, 8'h88, 1,   1, 1, C_SW,   1, 1, 3'd0, 3'd1, 3'd2, 8'h88, 0, 3'd1);
      add_vec(0, 0, 1, 3'd0, 3'd3, 3'd1, 3'd1, 8'h09, 0,   0, 1, C_SW,   1, 1, 3'd0, 3'd1, 3'd2, 8'h88, 0, 3'd1);
      add_vec(0, 0, 1, 3'd0, 3'd3, 3'd1, 3'd1, 8'h09, 0,   0, 1, C_SW,   1, 1, 3'd0, 3'd1, 3'd2, 8'h88, 0, 3'd1);
      add_vec(0, 0, 1, 3'd0, 3'd3, 3'd1, 3'd1, 8'h09, 0,   0, 1, C_SW,   1, 1, 3'd0, 3'd1, 3'd2, 8'h88, 0, 3'd1);
      add_vec(0, 0, 1, 3'd0, 3'd3, 3'd1, 3'd1, 8'h09, 1,   1, 1, C_ADD,  1, 1, 3'd3, 3'd1, 3'd1, 8'h09, 0, 3'd1);
      add_vec(0, 0, 1, 3'd6, 3'd2, 3'd1, 3'd1, 8'hAA, 1,   1, 0, C_NONE, 1, 0, 3'd0, 3'd0, 3'd0, 8'h00, 1, 3'd1);
      add_vec(0, 0, 1, 3'd1, 3'd2, 3'd3, 3'd0, 8'hBB, 1,   1, 1, C_ADDI, 1, 1, 3'd2, 3'd3, 3'd0, 8'hBB, 0, 3'd1);
      add_vec(0, 0, 1, 3'd4, 3'd1, 3'd2, 3'd3, 8'hCC, 1,   1, 1, C_SLL,  1, 1, 3'd1, 3'd2, 3'd3, 8'hCC, 0, 3'd1);
      add_vec(0, 1, 1, 3'd0, 3'd2, 3'd1, 3'd1, 8'hDD, 0,   0, 0, C_NONE, 0, 0, 3'd0, 3'd0, 3'd0, 8'h00, 0, 3'd1);
      add_vec(0, 0, 1, 3'd0, 3'd2, 3'd1, 3'd1, 8'hDD, 0,   1, 1, C_ADD,  1, 1, 3'd2, 3'd1, 3'd1, 8'hDD, 0, 3'd1);
      add_vec(0, 1, 1, 3'd7, 3'd2, 3'd1, 3'd1, 8'hEE, 1,   0, 0, C_NONE, 0, 0, 3'd0, 3'd0, 3'd0, 8'h00, 0, 3'd1);
      add_vec(0, 0, 1, 3'd3, 3'd3, 3'd0, 3'd0, 8'h01, 1,   1, 1, C_LW,   1, 1, 3'd3, 3'd0, 3'd0, 8'h01, 0, 3'd1);
      add_vec(0, 1, 1, 3'd0, 3'd1, 3'd3, 3'd0, 8'h02, 1,   0, 0, C_NONE, 0, 0, 3'd0, 3'd0, 3'd0, 8'h00, 0, 3'd1);
      add_vec(1, 1, 1, 3'd0, 3'd1, 3'd3, 3'd0, 8'h03, 1,   0, 0, C_NONE, 1, 1, 3'd0, 3'd0, 3'd0, 8'h00, 0, 3'd0);

      // Power-on reset and reset-state checks.
      drive(1, 0, 0, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00, 1);
      drive(1, 0, 0, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00, 1);
      @(posedge clk); #1;
      check("rst_valid", {31'd0, ex_valid}, 32'd0);
      check("rst_ctl", {27'd0, ctl_now()}, 32'd0);
      check("rst_fields", {15'd0, ex_rd, ex_rs1, ex_rs2, ex_imm}, 32'd0);
      check("rst_illegal", {31'd0, illegal}, 32'd0);
      check("rst_cnt", {29'd0, stall_count}, 32'd0);

      // Table sweep: in_ready is checked before the edge, EX state after it.
      for (int i = 0; i < tbl.size(); i++) begin
         cur_row = i;
         drive(tbl[i].rst, tbl[i].flush, tbl[i].iv, tbl[i].op, tbl[i].rd, tbl[i].rs1,
               tbl[i].rs2, tbl[i].imm, tbl[i].er);
         check("in_ready", {31'd0, in_ready}, {31'd0, tbl[i].x_rdy});
         @(posedge clk); #1;
         check("ex_valid", {31'd0, ex_valid}, {31'd0, tbl[i].x_valid});
         check("illegal", {31'd0, illegal}, {31'd0, tbl[i].x_ill});
         check("stall_count", {29'd0, stall_count}, {29'd0, tbl[i].x_cnt});
         if (tbl[i].cc) begin
            check("ex_ctl", {27'd0, ctl_now()}, {27'd0, tbl[i].x_ctl});
         end
         if (tbl[i].cf) begin
            check("ex_fields", {15'd0, ex_rd, ex_rs1, ex_rs2, ex_imm},
                  {15'd0, tbl[i].x_rd, tbl[i].x_rs1, tbl[i].x_rs2, tbl[i].x_imm});
         end
      end

      // A hazard with no instruction offered does not count as a stall.
      cur_row = 100;
      drive(0, 0, 1, 3'd3, 3'd2, 3'd1, 3'd0, 8'h10, 1);
      @(posedge clk); #1;
      drive(0, 0, 0, 3'd0, 3'd3, 3'd2, 3'd0, 8'h11, 1);
      check("idle_hazard_rdy", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      check("idle_hazard_cnt", {29'd0, stall_count}, 32'd0);
      check("idle_hazard_valid", {31'd0, ex_valid}, 32'd0);

      // Repeated load-use stalls drive the 3-bit counter to saturation at 7.
      for (int k = 0; k < 9; k++) begin
         cur_row = 200 + k;
         drive(0, 0, 1, 3'd3, 3'd2, 3'd1, 3'd0, 8'h20, 1);
         check("sat_lw_rdy", {31'd0, in_ready}, 32'd1);
         @(posedge clk); #1;
         drive(0, 0, 1, 3'd0, 3'd3, 3'd2, 3'd5, 8'h21, 1);
         check("sat_haz_rdy", {31'd0, in_ready}, 32'd0);
         @(posedge clk); #1;
         check("sat_cnt", {29'd0, stall_count}, (k < 6) ? (k + 1) : 32'd7);
         drive(0, 0, 1, 3'd0, 3'd3, 3'd2, 3'd5, 8'h21, 1);
         check("sat_add_rdy", {31'd0, in_ready}, 32'd1);
         @(posedge clk); #1;
         check("sat_add_valid", {31'd0, ex_valid}, 32'd1);
      end

      drive(0, 0, 0, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
